// File: rtl/pwm_peripheral_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_peripheral_pkg
// Brief    : Shared widths, constants and pin-drive helper for the PWM block.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_peripheral_pkg;

    localparam int                   PWM_CNT_W = 8;
    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
    localparam int                   NUM_PINS  = 16;

    // A pin is low unless enabled; an enabled pin follows the PWM only if selected.
    function automatic logic [NUM_PINS-1:0] pin_drive(
        input logic [NUM_PINS-1:0] en_out,
        input logic [NUM_PINS-1:0] en_pwm,
        input logic                pwm_sig
    );
        return en_out & (~en_pwm | {NUM_PINS{pwm_sig}});
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_peripheral_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_peripheral_if
// Brief    : Control-register inputs and pad outputs of the PWM peripheral.
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_peripheral_if;
    import pwm_peripheral_pkg::*;

    logic [7:0]          en_reg_out_7_0;
    logic [7:0]          en_reg_out_15_8;
    logic [7:0]          en_reg_pwm_7_0;
    logic [7:0]          en_reg_pwm_15_8;
    logic [7:0]          pwm_duty_cycle;
    logic [NUM_PINS-1:0] out;
    logic                period_start;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out,
        input  period_start
    );

    modport slave (
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out,
        output period_start
    );

endinterface
`default_nettype wire

// File: rtl/pwm_peripheral_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : pwm_tick_gen
// Brief    : Prescaler; pulses o_tick once every PRESCALE clk cycles.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_tick_gen #(
    parameter int PRESCALE = 13
) (
    input  wire logic clk,
    input  wire logic rst_n,
    output logic      o_tick
);

    localparam int                 c_DIV_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(PRESCALE - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic               w_tick;

    // With PRESCALE=1 the counter sits at 0 and ticks every clk.
    assign w_tick = (r_div_cnt == c_DIV_LAST);
    assign o_tick = w_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_DIV_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : pwm_peripheral
// Brief    : 16-pin output driver with one shared 256-step PWM and duty shadow.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_peripheral
    import pwm_peripheral_pkg::*;
#(
    parameter int PRESCALE = 13
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    pwm_peripheral_if.slave  bus
);

    localparam logic [PWM_CNT_W-1:0] c_CNT_LAST = {PWM_CNT_W{1'b1}};
    localparam logic [PWM_CNT_W-1:0] c_CNT_ONE  = PWM_CNT_W'(1);

    logic                 w_tick;
    logic                 w_wrap;
    logic                 w_pwm_sig;
    logic [NUM_PINS-1:0]  w_en_out;
    logic [NUM_PINS-1:0]  w_en_pwm;

    logic [PWM_CNT_W-1:0] r_pwm_cnt;
    logic [PWM_CNT_W-1:0] r_duty_active;
    logic [NUM_PINS-1:0]  r_out;
    logic                 r_period_start;

    pwm_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    assign w_wrap    = w_tick && (r_pwm_cnt == c_CNT_LAST);
    assign w_en_out  = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign w_en_pwm  = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    // Full-scale duty is special-cased so the wrap cycle does not dip low.
    assign w_pwm_sig = (r_duty_active == DUTY_FULL) || (r_pwm_cnt < r_duty_active);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + c_CNT_ONE;
        end
    end

    // Duty is only sampled at the period boundary so a period never gets a runt pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_active  <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_wrap;
            if (w_wrap) begin
                r_duty_active <= bus.pwm_duty_cycle;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= pin_drive(w_en_out, w_en_pwm, w_pwm_sig);
        end
    end

    assign bus.out          = r_out;
    assign bus.period_start = r_period_start;

endmodule
`default_nettype wire

// File: tb/tb_pwm_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_peripheral
// Brief    : Directed scoreboard bench for pwm_peripheral at PRESCALE=13.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_peripheral;
    import pwm_peripheral_pkg::*;

    localparam int PRESCALE = 13;
    localparam int PERIOD   = 256 * PRESCALE;
    localparam int TIMEOUT  = PERIOD + 700;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pwm_peripheral_if bus ();

    pwm_peripheral #(
        .PRESCALE (PRESCALE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    int    exp_q[$];
    string tag_q[$];

    task automatic sb_push(input string tag, input int exp_val);
        tag_q.push_back(tag);
        exp_q.push_back(exp_val);
    endtask

    task automatic sb_check(input int obs);
        string tag;
        int    exp_val;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_underflow observed=%0d expected=none", obs);
        end else begin
            tag     = tag_q.pop_front();
            exp_val = exp_q.pop_front();
            assert (obs === exp_val) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_val);
            end
        end
    endtask

    task automatic set_regs(input logic [15:0] en_out, input logic [15:0] en_pwm,
                            input logic [7:0] duty);
        bus.en_reg_out_7_0  = en_out[7:0];
        bus.en_reg_out_15_8 = en_out[15:8];
        bus.en_reg_pwm_7_0  = en_pwm[7:0];
        bus.en_reg_pwm_15_8 = en_pwm[15:8];
        bus.pwm_duty_cycle  = duty;
    endtask

    // Entered on a period_start cycle; returns on the next period_start cycle.
    task automatic measure_period(input int wr_at, input logic [7:0] wr_val,
                                  output int len, output int hi, output int bad);
        len = 0;
        hi  = 0;
        bad = 0;
        do begin
            if (bus.out[7:0] == 8'hFF) hi++;
            if ((bus.out[7:0] != 8'hFF && bus.out[7:0] != 8'h00) || bus.out[15:8] != 8'h00) bad++;
            len++;
            if (len == wr_at) bus.pwm_duty_cycle = wr_val;
            @(negedge clk);
        end while (!bus.period_start && len < TIMEOUT);
    endtask

    task automatic check_period(input string name, input int wr_at, input logic [7:0] wr_val,
                                input int exp_hi);
        int len, hi, bad;
        sb_push({name, "_len"}, PERIOD);
        sb_push({name, "_hi"}, exp_hi);
        sb_push({name, "_bad"}, 0);
        measure_period(wr_at, wr_val, len, hi, bad);
        sb_check(len);
        sb_check(hi);
        sb_check(bad);
    endtask

    initial begin
        int n;
        int hi;

        set_regs(16'h0000, 16'h0000, 8'h00);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        sb_push("reset_out", 0);
        sb_check(int'(bus.out));
        sb_push("reset_period_start", 0);
        sb_check(int'(bus.period_start));

        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        sb_push("idle_out", 0);
        sb_check(int'(bus.out));

        // Static enable: one clk of latency in each direction.
        set_regs(16'h0001, 16'h0000, 8'h00);
        sb_push("en_same_clk", 0);
        sb_check(int'(bus.out));
        @(negedge clk);
        sb_push("en_1clk", 1);
        sb_check(int'(bus.out));
        set_regs(16'h0000, 16'h0000, 8'h00);
        @(negedge clk);
        sb_push("en_clear", 0);
        sb_check(int'(bus.out));
        set_regs(16'h0001, 16'h0001, 8'h00);
        @(negedge clk);
        sb_push("pwm_sel_duty0", 0);
        sb_check(int'(bus.out));

        // First period after reset runs at duty 0 even with 0x80 written.
        set_regs(16'h00FF, 16'h00FF, 8'h80);
        n  = 0;
        hi = 0;
        while (!bus.period_start && n < TIMEOUT) begin
            if (bus.out != 16'h0000) hi++;
            @(negedge clk);
            n++;
        end
        sb_push("first_period_hi", 0);
        sb_check(hi);
        sb_push("first_start_seen", 1);
        sb_check(int'(bus.period_start));

        check_period("d80_a", 0, 8'h00, 1664);
        bus.pwm_duty_cycle = 8'h00;
        check_period("d80_b", 0, 8'h00, 1664);
        bus.pwm_duty_cycle = 8'hFF;
        check_period("d00", 0, 8'h00, 0);
        check_period("dff_first", 0, 8'h00, PERIOD - 1);
        check_period("dff_full", 0, 8'h00, PERIOD);
        bus.pwm_duty_cycle = 8'h40;
        check_period("dff_wrap", 0, 8'h00, PERIOD);
        check_period("d40_first", 0, 8'h00, 833);
        check_period("d40_midwr", 1000, 8'hC0, 832);
        check_period("dc0", 0, 8'h00, 2496);

        // Async reset during the high phase.
        repeat (100) @(negedge clk);
        sb_push("mid_high_out", 16'h00FF);
        sb_check(int'(bus.out));
        #2;
        rst_n = 1'b0;
        #1;
        sb_push("async_reset_out", 0);
        sb_check(int'(bus.out));
        sb_push("async_reset_pstart", 0);
        sb_check(int'(bus.period_start));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n  = 0;
        hi = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.out != 16'h0000) hi++;
        end while (!bus.period_start && n < TIMEOUT);
        sb_push("post_reset_first_start", PERIOD);
        sb_check(n);
        sb_push("post_reset_low", 0);
        sb_check(hi);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
